// File: rtl/vend_display_encoder_pkg.sv
// Shared types and constants for the vending display encoder: sale states,
// digit codes understood by the seven-segment decoders, and coin values.
package vend_display_encoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_SUM      = 2'b01,
        ST_DISPENSE = 2'b10,
        ST_CHANGE   = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        COIN_NONE = 2'b00,
        COIN_1    = 2'b01,
        COIN_5    = 2'b10,
        COIN_10   = 2'b11
    } coin_t;

    localparam logic [3:0] DIG_BLANK  = 4'b1111;
    localparam logic [3:0] DIG_BREATH = 4'b1000;
    localparam logic [6:0] SUM_MAX    = 7'd99;

    function automatic logic [6:0] coin_value(input logic [1:0] code);
        case (code)
            COIN_1:  return 7'd1;
            COIN_5:  return 7'd5;
            COIN_10: return 7'd10;
            default: return 7'd0;
        endcase
    endfunction

endpackage

// File: rtl/vend_display_encoder_if.sv
// Front-panel bus: coin/button pulses in, digit codes and sale pulses out.
interface vend_display_encoder_if;
    logic [1:0] coin_in;
    logic       buy;
    logic       cancel;
    logic       state_chg;
    logic [3:0] dig_tens;
    logic [3:0] dig_ones;
    logic       vend;
    logic       coin_reject;

    modport master (
        output coin_in, buy, cancel,
        input  state_chg, dig_tens, dig_ones, vend, coin_reject
    );

    modport slave (
        input  coin_in, buy, cancel,
        output state_chg, dig_tens, dig_ones, vend, coin_reject
    );
endinterface

// File: rtl/vend_display_encoder_bin2bcd99.sv
// Combinational 0..99 binary to two-digit BCD by repeated subtract-by-10.
module bin2bcd99 (
    input  logic [6:0] bin,
    output logic [3:0] tens,
    output logic [3:0] ones
);
    logic [6:0] rem;

    always_comb begin
        rem  = bin;
        tens = 4'd0;
        for (int i = 0; i < 9; i++) begin
            if (rem >= 7'd10) begin
                rem  = rem - 7'd10;
                tens = tens + 4'd1;
            end
        end
        ones = rem[3:0];
    end
endmodule

// File: rtl/vend_display_encoder.sv
// Vending front end: coin accumulation, sale sequencing and digit-code generation
// for the downstream seven-segment decoders. All outputs are registered.
module vend_display_encoder
    import vend_display_encoder_pkg::*;
#(
    parameter int unsigned PRICE         = 15,
    parameter int unsigned BLINK_CYCLES  = 4,
    parameter int unsigned DISP_BLINKS   = 4,
    parameter int unsigned CHANGE_CYCLES = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    vend_display_encoder_if.slave  bus
);
    state_t      state, state_n;
    logic [6:0]  sum, sum_n, chg, chg_n, sum_add, coin_v;
    logic [15:0] cyc, cyc_n, ph, ph_n;
    logic        coin_any, vend_n, rej_n;
    logic [3:0]  tens_n, ones_n, sum_tens, sum_ones, chg_tens, chg_ones;
    logic        state_chg_r, vend_r, rej_r;
    logic [3:0]  tens_r, ones_r;

    // BCD is taken from the next-state values so the display lands on the same edge.
    bin2bcd99 u_sum_bcd (.bin(sum_n), .tens(sum_tens), .ones(sum_ones));
    bin2bcd99 u_chg_bcd (.bin(chg_n), .tens(chg_tens), .ones(chg_ones));

    always_comb begin
        coin_v   = coin_value(bus.coin_in);
        coin_any = (bus.coin_in != COIN_NONE);
        sum_add  = sum + coin_v;
        state_n  = state;
        sum_n    = sum;
        chg_n    = chg;
        cyc_n    = cyc;
        ph_n     = ph;
        vend_n   = 1'b0;
        rej_n    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (coin_any) begin
                    sum_n   = sum_add;
                    state_n = ST_SUM;
                end
            end
            ST_SUM: begin
                if (bus.cancel) begin
                    chg_n   = sum;
                    cyc_n   = '0;
                    rej_n   = coin_any;
                    state_n = ST_CHANGE;
                end else if (bus.buy && sum >= 7'(PRICE)) begin
                    chg_n   = sum - 7'(PRICE);
                    cyc_n   = '0;
                    ph_n    = '0;
                    vend_n  = 1'b1;
                    rej_n   = coin_any;
                    state_n = ST_DISPENSE;
                end else if (coin_any) begin
                    if (sum_add <= SUM_MAX) sum_n = sum_add;
                    else                    rej_n = 1'b1;
                end
            end
            ST_DISPENSE: begin
                rej_n = coin_any;
                if (cyc == 16'(BLINK_CYCLES - 1)) begin
                    cyc_n = '0;
                    if (ph == 16'(DISP_BLINKS - 1)) begin
                        ph_n    = '0;
                        state_n = ST_CHANGE;
                    end else begin
                        ph_n = ph + 16'd1;
                    end
                end else begin
                    cyc_n = cyc + 16'd1;
                end
            end
            default: begin
                rej_n = coin_any;
                if (cyc == 16'(CHANGE_CYCLES - 1)) begin
                    cyc_n   = '0;
                    sum_n   = '0;
                    chg_n   = '0;
                    state_n = ST_IDLE;
                end else begin
                    cyc_n = cyc + 16'd1;
                end
            end
        endcase

        tens_n = DIG_BLANK;
        ones_n = DIG_BLANK;
        case (state_n)
            ST_SUM: begin
                tens_n = (sum_n < 7'd10) ? DIG_BLANK : sum_tens;
                ones_n = sum_ones;
            end
            ST_DISPENSE: begin
                tens_n = ph_n[0] ? DIG_BLANK : DIG_BREATH;
                ones_n = tens_n;
            end
            ST_CHANGE: begin
                tens_n = (chg_n < 7'd10) ? DIG_BLANK : chg_tens;
                ones_n = chg_ones;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            sum         <= '0;
            chg         <= '0;
            cyc         <= '0;
            ph          <= '0;
            state_chg_r <= 1'b0;
            tens_r      <= DIG_BLANK;
            ones_r      <= DIG_BLANK;
            vend_r      <= 1'b0;
            rej_r       <= 1'b0;
        end else begin
            state       <= state_n;
            sum         <= sum_n;
            chg         <= chg_n;
            cyc         <= cyc_n;
            ph          <= ph_n;
            state_chg_r <= (state_n == ST_CHANGE);
            tens_r      <= tens_n;
            ones_r      <= ones_n;
            vend_r      <= vend_n;
            rej_r       <= rej_n;
        end
    end

    assign bus.state_chg   = state_chg_r;
    assign bus.dig_tens    = tens_r;
    assign bus.dig_ones    = ones_r;
    assign bus.vend        = vend_r;
    assign bus.coin_reject = rej_r;
endmodule

// File: tb/tb_vend_display_encoder.sv
// Bench for vend_display_encoder: directed scenarios plus random traffic,
// checked every cycle against a time-based behavioural model.
module tb_vend_display_encoder;
    localparam int PRICE = 15, BC = 4, DB = 4, CC = 8;
    localparam int M_IDLE = 0, M_SUM = 1, M_DISP = 2, M_CHG = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0, bad = 0;

    // model: mode, amounts, cycles spent in current mode, last-cycle pulses
    int m_mode = M_IDLE, m_sum = 0, m_chg = 0, m_t = 0;
    bit m_vend = 0, m_rej = 0;

    vend_display_encoder_if bus ();

    vend_display_encoder #(
        .PRICE(PRICE), .BLINK_CYCLES(BC), .DISP_BLINKS(DB), .CHANGE_CYCLES(CC)
    ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    function automatic int cval(input logic [1:0] c);
        return (c == 2'd1) ? 1 : (c == 2'd2) ? 5 : (c == 2'd3) ? 10 : 0;
    endfunction

    function automatic logic [10:0] obs();
        return {bus.state_chg, bus.dig_tens, bus.dig_ones, bus.vend, bus.coin_reject};
    endfunction

    function automatic logic [10:0] exp_vec();
        logic [3:0] t, o;
        t = 4'hF; o = 4'hF;
        if (m_mode == M_SUM) begin
            t = (m_sum < 10) ? 4'hF : 4'(m_sum / 10);
            o = 4'(m_sum % 10);
        end else if (m_mode == M_DISP) begin
            t = (((m_t / BC) % 2) == 0) ? 4'h8 : 4'hF;
            o = t;
        end else if (m_mode == M_CHG) begin
            t = (m_chg < 10) ? 4'hF : 4'(m_chg / 10);
            o = 4'(m_chg % 10);
        end
        return {(m_mode == M_CHG), t, o, m_vend, m_rej};
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_sum = 0; m_chg = 0; m_t = 0; m_vend = 0; m_rej = 0;
    endtask

    task automatic model_step(input logic [1:0] c, input bit b, input bit k);
        int v;
        v = cval(c);
        m_vend = 0; m_rej = 0;
        case (m_mode)
            M_IDLE: if (v != 0) begin m_sum += v; m_mode = M_SUM; end
            M_SUM: begin
                if (k) begin
                    m_chg = m_sum; m_mode = M_CHG; m_t = 0; m_rej = (v != 0);
                end else if (b && m_sum >= PRICE) begin
                    m_chg = m_sum - PRICE; m_vend = 1; m_mode = M_DISP; m_t = 0; m_rej = (v != 0);
                end else if (v != 0) begin
                    if (m_sum + v <= 99) m_sum += v; else m_rej = 1;
                end
            end
            M_DISP: begin
                m_rej = (v != 0); m_t++;
                if (m_t == DB * BC) begin m_mode = M_CHG; m_t = 0; end
            end
            default: begin
                m_rej = (v != 0); m_t++;
                if (m_t == CC) begin m_mode = M_IDLE; m_sum = 0; m_chg = 0; m_t = 0; end
            end
        endcase
    endtask

    // one clock: drive at negedge, advance model at posedge, return #1 later
    task automatic cycle(input logic [1:0] c, input bit b, input bit k);
        @(negedge clk);
        bus.coin_in = c; bus.buy = b; bus.cancel = k;
        @(posedge clk);
        model_step(c, b, k);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.coin_in = 2'd0; bus.buy = 1'b0; bus.cancel = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        bus.coin_in = 2'd0; bus.buy = 1'b0; bus.cancel = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (obs() !== 11'b0_1111_1111_0_0) begin
            bad++; $display("FAIL reset_values got=%b want=%b", obs(), 11'b0_1111_1111_0_0);
        end
        rst_n = 1'b1;
        cycle(2'd0, 0, 0);
        total++;
        if (obs() !== 11'b0_1111_1111_0_0) begin
            bad++; $display("FAIL idle_blank got=%b want=%b", obs(), 11'b0_1111_1111_0_0);
        end
    endtask

    task automatic test_first_coin();
        cycle(2'd3, 0, 0);
        total++;
        if ({bus.dig_tens, bus.dig_ones} !== 8'h10 || obs() !== exp_vec()) begin
            bad++; $display("FAIL first_coin got=%b want=%b", obs(), exp_vec());
        end
    endtask

    task automatic test_purchase();
        int breath, blanks, chg_cycles;
        breath = 0; blanks = 0; chg_cycles = 0;
        do_reset();
        cycle(2'd3, 0, 0);
        cycle(2'd3, 0, 0);
        cycle(2'd0, 1, 0);
        total++;
        if (bus.vend !== 1'b1 || obs() !== exp_vec()) begin
            bad++; $display("FAIL purchase_vend got=%b want=%b", obs(), exp_vec());
        end
        for (int i = 0; i < DB * BC + CC + 2; i++) begin
            if (bus.dig_tens == 4'h8) breath++;
            if (bus.state_chg && bus.dig_ones == 4'h5 && bus.dig_tens == 4'hF) chg_cycles++;
            if (!bus.state_chg && bus.dig_tens == 4'hF && i < DB * BC) blanks++;
            total++;
            if (obs() !== exp_vec()) begin
                bad++; $display("FAIL purchase_seq cyc=%0d got=%b want=%b", i, obs(), exp_vec());
            end
            cycle(2'd0, 0, 0);
        end
        total++;
        if (breath != 8 || blanks != 8 || chg_cycles != CC) begin
            bad++; $display("FAIL purchase_counts got=%0d/%0d/%0d want=8/8/%0d", breath, blanks, chg_cycles, CC);
        end
        total++;
        if (obs() !== 11'b0_1111_1111_0_0) begin
            bad++; $display("FAIL purchase_idle got=%b want=%b", obs(), 11'b0_1111_1111_0_0);
        end
    endtask

    task automatic test_insufficient();
        do_reset();
        cycle(2'd2, 0, 0);
        cycle(2'd1, 0, 0);
        cycle(2'd0, 1, 0);
        total++;
        if (obs() !== 11'b0_1111_0110_0_0 || obs() !== exp_vec()) begin
            bad++; $display("FAIL insufficient got=%b want=%b", obs(), 11'b0_1111_0110_0_0);
        end
        // ignored buy lets a same-cycle coin through
        cycle(2'd2, 1, 0);
        total++;
        if (obs() !== 11'b0_0001_0001_0_0 || obs() !== exp_vec()) begin
            bad++; $display("FAIL buy_ignored_coin got=%b want=%b", obs(), 11'b0_0001_0001_0_0);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        repeat (9) cycle(2'd3, 0, 0);
        cycle(2'd2, 0, 0);
        cycle(2'd3, 0, 0);
        total++;
        if (obs() !== 11'b0_1001_0101_0_1 || obs() !== exp_vec()) begin
            bad++; $display("FAIL saturate_reject got=%b want=%b", obs(), 11'b0_1001_0101_0_1);
        end
        cycle(2'd1, 0, 0);
        total++;
        if (obs() !== 11'b0_1001_0110_0_0 || obs() !== exp_vec()) begin
            bad++; $display("FAIL saturate_accept got=%b want=%b", obs(), 11'b0_1001_0110_0_0);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        cycle(2'd3, 0, 0);
        cycle(2'd3, 0, 0);
        cycle(2'd2, 1, 1);
        total++;
        if (obs() !== 11'b1_0010_0000_0_1 || obs() !== exp_vec()) begin
            bad++; $display("FAIL simultaneous got=%b want=%b", obs(), 11'b1_0010_0000_0_1);
        end
    endtask

    task automatic test_reset_mid_sale();
        do_reset();
        cycle(2'd3, 0, 0);
        cycle(2'd3, 0, 0);
        cycle(2'd0, 1, 0);
        repeat (3) cycle(2'd0, 0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        total++;
        if (obs() !== 11'b0_1111_1111_0_0) begin
            bad++; $display("FAIL mid_sale_reset got=%b want=%b", obs(), 11'b0_1111_1111_0_0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cycle(2'd1, 0, 0);
        total++;
        if (obs() !== 11'b0_1111_0001_0_0 || obs() !== exp_vec()) begin
            bad++; $display("FAIL after_reset_coin got=%b want=%b", obs(), 11'b0_1111_0001_0_0);
        end
    endtask

    task automatic test_random();
        logic [1:0] c;
        bit b, k;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            c = ($urandom_range(0, 99) < 40) ? 2'($urandom_range(1, 3)) : 2'd0;
            b = ($urandom_range(0, 99) < 12);
            k = ($urandom_range(0, 99) < 4);
            cycle(c, b, k);
            total++;
            if (obs() !== exp_vec()) begin
                bad++; $display("FAIL random cyc=%0d got=%b want=%b", i, obs(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_coin();
        test_purchase();
        test_insufficient();
        test_saturation();
        test_simultaneous();
        test_reset_mid_sale();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
